atomic_unit: RTL and testbench
==============================

Name: atomic_unit

Overview:
Multi-cycle execution unit for RV32A. It services LR.W, SC.W and AMO*.W once the decoder has flagged them (is_lr/is_sc/is_amo, amo_funct5), and stalls the pipeline via busy. It drives a single-outstanding-request data-memory port and performs the read-modify-write sequence. It also holds the LR/SC reservation. It sits in the MEM stage, in parallel with the normal load/store path.

Parameters:
XLEN, 32, data/address width
RESV_TIMEOUT, 64, cycles before a reservation self-expires (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only in IDLE
is_lr  input  1  operation is LR.W
is_sc  input  1  operation is SC.W
is_amo  input  1  operation is AMO*.W
amo_funct5  input  5  instruction[31:27]
addr  input  XLEN  effective address (rs1)
rs2_data  input  XLEN  store/operand value
resv_clear  input  1  invalidate reservation (trap, external store hit, context switch)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
result  output  XLEN  value for rd; valid while done is high
misaligned  output  1  pulses with done when addr[1:0]!=0
illegal  output  1  pulses with done for an unknown AMO funct5
mem_req  output  1  memory request
mem_we  output  1  write enable
mem_addr  output  XLEN  word address
mem_wdata  output  XLEN  write data
mem_rdata  input  XLEN  read data, valid with mem_ready on a read
mem_ready  input  1  request completes this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - Outputs busy, done, misaligned, illegal, mem_req and mem_we = 0.
  - result, mem_addr and mem_wdata = 0.
  - Reservation valid = 0.
  - Reset mid-transaction abandons the request immediately; mem_req drops asynchronously.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE + start: latch operands and go to READ. Exceptions:
    - Misaligned address: go to RESP with misaligned=1.
    - AMO with illegal funct5: go to RESP with illegal=1.
    - SC with failed check: go to RESP with result=1 and no memory access.
  - READ: mem_req=1, mem_we=0, mem_addr held stable until mem_ready. On mem_ready, capture rdata.
    - LR: set reservation (valid=1, addr), result=rdata, go to RESP.
    - AMO: result=rdata, compute new value, go to WRITE.
  - SC success path: from IDLE go directly to WRITE with mem_wdata=rs2_data.
  - WRITE: mem_req=1, mem_we=1, held until mem_ready, then go to RESP.
    - SC: result=0.
    - AMO: result keeps the old value.
  - RESP: done=1 for one cycle, then IDLE. busy is low in IDLE only.
- Latency with zero-wait memory:
  - LR: 2 cycles start→done.
  - AMO: 3 cycles.
  - Failed SC / misaligned: 1 cycle.
- SC check: reservation valid and reserved word address == addr[XLEN-1:2].
  - Every SC clears the reservation, pass or fail.
  - An AMO to the reserved word clears it.
- resv_clear: clears the reservation in any state.
  - If asserted in the same cycle an SC is accepted, the SC fails.
  - If asserted in the same cycle an LR sets the reservation, the set wins.
- AMO ops by amo_funct5:
  - 00001 SWAP=rs2
  - 00000 ADD (wraps mod 2^XLEN)
  - 00100 XOR
  - 01100 AND
  - 01000 OR
  - 10000 MIN (signed)
  - 10100 MAX (signed)
  - 11000 MINU
  - 11100 MAXU
  - Any other encoding is illegal.
- start while busy: ignored. More than one of is_lr/is_sc/is_amo set: priority LR > SC > AMO.
- aq/rl bits are ignored; the single outstanding request already gives ordering.

Optional Feature:
Macro ATOMIC_RESV_TIMEOUT_EN.
- Defined: a counter loads RESV_TIMEOUT when a reservation is set and decrements each cycle. At 0 the reservation clears, which guarantees forward progress for other harts.
- Undefined: no counter; the reservation persists until SC, resv_clear, a matching AMO, or reset.

Decomposition:
- Add to definitions.v as `define constants:
  - AMO funct5 encodings
  - FSM state encodings
  - SC result codes (SC_PASS=0, SC_FAIL=1)
- Sub-module amo_alu: purely combinational (funct5, old, rs2 → new, illegal), instantiated once.

Test Plan:
- LR.W to 0x100 (mem=0xDEADBEEF), then SC.W 0x100 rs2=5 → LR result 0xDEADBEEF; SC writes 5 to 0x100, result 0.
- SC.W to 0x100 with no prior LR → no mem_req; result 1 after 1 cycle.
- LR 0x100, then resv_clear pulse, then SC 0x100 → SC result 1; memory unchanged.
- AMOADD 0x200 (mem=0x7FFFFFFF), rs2=1 → result 0x7FFFFFFF; mem becomes 0x80000000.
- AMOMIN vs AMOMINU, mem=0xFFFFFFFF, rs2=1 → MIN writes 0xFFFFFFFF; MINU writes 1.
- AMO with addr=0x202 → misaligned=1 with done, no mem_req; funct5=00010 treated as AMO → illegal=1.
- With ATOMIC_RESV_TIMEOUT_EN, RESV_TIMEOUT=64: LR, wait 64 cycles, SC → result 1.
- Reset asserted during WRITE with mem_ready low → mem_req drops immediately; a following SC fails.

Source files
------------

// File: rtl/atomic_unit_pkg.sv
// atomic_unit_pkg
// Shared definitions for the RV32A atomic unit: FSM state encoding, decoded
// operation kind, AMO funct5 encodings, SC result codes, and the helper that
// resolves the LR > SC > AMO priority when the decoder flags more than one.
package atomic_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_LR  = 2'd0,
    OP_SC  = 2'd1,
    OP_AMO = 2'd2
  } op_t;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  localparam logic SC_PASS = 1'b0;
  localparam logic SC_FAIL = 1'b1;

  // LR wins over SC, SC wins over AMO.
  function automatic op_t decode_op(input logic lr, input logic sc);
    if (lr)      return OP_LR;
    else if (sc) return OP_SC;
    else         return OP_AMO;
  endfunction

endpackage

// File: rtl/atomic_unit_amo_alu.sv
// amo_alu
// Purely combinational AMO operator: given funct5, the old memory word and
// the rs2 operand, produces the value to write back and flags encodings that
// are not a defined AMO.
// Ports:
//   funct5  - instruction[31:27]
//   old_val - word read from memory
//   rs2     - operand from rs2
//   new_val - value to store back
//   illegal - funct5 is not a defined AMO encoding
module amo_alu
  import atomic_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] new_val,
  output logic            illegal
);

  always_comb begin
    new_val = old_val;
    illegal = 1'b0;
    case (funct5)
      AMO_SWAP: new_val = rs2;
      AMO_ADD:  new_val = old_val + rs2;
      AMO_XOR:  new_val = old_val ^ rs2;
      AMO_AND:  new_val = old_val & rs2;
      AMO_OR:   new_val = old_val | rs2;
      AMO_MIN:  new_val = ($signed(old_val) < $signed(rs2)) ? old_val : rs2;
      AMO_MAX:  new_val = ($signed(old_val) > $signed(rs2)) ? old_val : rs2;
      AMO_MINU: new_val = (old_val < rs2) ? old_val : rs2;
      AMO_MAXU: new_val = (old_val > rs2) ? old_val : rs2;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/atomic_unit.sv
// atomic_unit
// Multi-cycle RV32A execution unit (LR.W / SC.W / AMO*.W) in the MEM stage.
// Runs the read-modify-write sequence on a single-outstanding-request data
// memory port and holds the LR/SC reservation.
//
// Optional feature: define ATOMIC_RESV_TIMEOUT_EN to make a reservation
// self-expire RESV_TIMEOUT cycles after it is set.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   start            - request pulse, accepted only in IDLE
//   is_lr/is_sc/is_amo, amo_funct5, addr, rs2_data - decoded operation
//   resv_clear       - invalidate the reservation (any state)
//   busy             - unit occupied (every state except IDLE)
//   done             - one-cycle completion pulse; result valid with it
//   result           - value for rd
//   misaligned       - pulses with done when addr[1:0] != 0
//   illegal          - pulses with done for an undefined AMO funct5
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready - memory port
//
// Memory handshake: mem_req acts as valid and mem_ready as ready. Once
// mem_req rises, mem_we/mem_addr/mem_wdata stay stable until the cycle in
// which mem_ready is high; that cycle completes the transfer (and mem_rdata is
// sampled on a read). Only one request is ever outstanding.
module atomic_unit
  import atomic_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESV_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_lr,
  input  logic            is_sc,
  input  logic            is_amo,
  input  logic [4:0]      amo_funct5,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            resv_clear,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            misaligned,
  output logic            illegal,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  state_t            state_q, state_d;
  op_t               op_q, op_d, start_op;
  logic [4:0]        funct5_q, funct5_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic              ill_q, ill_d;

  logic              resv_valid_q;
  logic [XLEN-3:0]   resv_word_q;
  logic              resv_set, resv_kill, resv_expire;
  logic              word_hit, sc_ok;

  logic              any_op, start_mis, start_ill;
  logic [4:0]        alu_funct5;
  logic [XLEN-1:0]   alu_new;
  logic              alu_illegal;

  assign any_op   = is_lr | is_sc | is_amo;
  assign start_op = decode_op(is_lr, is_sc);

  // The single ALU serves both the legality check at accept time (live
  // funct5) and the write-back value during READ (latched funct5).
  assign alu_funct5 = (state_q == ST_IDLE) ? amo_funct5 : funct5_q;

  amo_alu #(.XLEN(XLEN)) u_amo_alu (
    .funct5  (alu_funct5),
    .old_val (mem_rdata),
    .rs2     (rs2_q),
    .new_val (alu_new),
    .illegal (alu_illegal)
  );

  assign start_mis = (addr[1:0] != 2'b00);
  assign start_ill = (start_op == OP_AMO) && alu_illegal;

  assign word_hit = resv_valid_q && (resv_word_q == addr[XLEN-1:2]);
  // A clear or expiry arriving with the SC makes it fail.
  assign sc_ok    = word_hit && !resv_clear && !resv_expire;

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct5_d  = funct5_q;
    rs2_d     = rs2_q;
    result_d  = result_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    ill_d     = ill_q;
    resv_set  = 1'b0;
    resv_kill = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && any_op) begin
          op_d     = start_op;
          funct5_d = amo_funct5;
          rs2_d    = rs2_data;
          addr_d   = {addr[XLEN-1:2], 2'b00};
          mis_d    = start_mis;
          ill_d    = start_ill;
          result_d = '0;
          // Every SC consumes the reservation; a real AMO to the reserved
          // word does too.
          if (start_op == OP_SC) begin
            resv_kill = 1'b1;
          end else if (start_op == OP_AMO && !start_mis && !start_ill && word_hit) begin
            resv_kill = 1'b1;
          end

          if (start_mis || start_ill) begin
            state_d = ST_RESP;
          end else if (start_op == OP_SC) begin
            if (sc_ok) begin
              wdata_d = rs2_data;
              state_d = ST_WRITE;
            end else begin
              result_d = {{(XLEN-1){1'b0}}, SC_FAIL};
              state_d  = ST_RESP;
            end
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (mem_ready) begin
          result_d = mem_rdata;
          if (op_q == OP_LR) begin
            resv_set = 1'b1;
            state_d  = ST_RESP;
          end else begin
            wdata_d = alu_new;
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (mem_ready) begin
          // AMO keeps the old value already in result.
          if (op_q == OP_SC) begin
            result_d = {{(XLEN-1){1'b0}}, SC_PASS};
          end
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        mis_d   = 1'b0;
        ill_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LR;
      funct5_q <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      funct5_q <= funct5_d;
      rs2_q    <= rs2_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end

  // Reservation: an LR setting it wins over any simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid_q <= 1'b0;
      resv_word_q  <= '0;
    end else if (resv_set) begin
      resv_valid_q <= 1'b1;
      resv_word_q  <= addr_q[XLEN-1:2];
    end else if (resv_clear || resv_kill || resv_expire) begin
      resv_valid_q <= 1'b0;
    end
  end

`ifdef ATOMIC_RESV_TIMEOUT_EN
  localparam int CNT_W = $clog2(RESV_TIMEOUT + 1);
  logic [CNT_W-1:0] resv_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_cnt_q <= '0;
    end else if (resv_set) begin
      resv_cnt_q <= CNT_W'(RESV_TIMEOUT);
    end else if (resv_valid_q && resv_cnt_q != '0) begin
      resv_cnt_q <= resv_cnt_q - 1'b1;
    end
  end

  assign resv_expire = resv_valid_q && (resv_cnt_q == '0);
`else
  assign resv_expire = 1'b0;
`endif

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_RESP);
  assign result     = result_q;
  assign misaligned = done && mis_q;
  assign illegal    = done && ill_q;
  assign mem_req    = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_atomic_unit.sv
// tb_atomic_unit
// Bench for atomic_unit: a behavioural word memory answers the DUT's memory
// port (zero-wait or random wait states), expected completions are queued
// when an operation is issued and compared when done pulses.
module tb_atomic_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            is_lr = 1'b0;
  logic            is_sc = 1'b0;
  logic            is_amo = 1'b0;
  logic [4:0]      amo_funct5 = '0;
  logic [XLEN-1:0] addr = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            resv_clear = 1'b0;
  logic            busy, done, misaligned, illegal, mem_req, mem_we;
  logic [XLEN-1:0] result, mem_addr, mem_wdata;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_ready = 1'b0;

  atomic_unit #(.XLEN(XLEN), .RESV_TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_lr      (is_lr),
    .is_sc      (is_sc),
    .is_amo     (is_amo),
    .amo_funct5 (amo_funct5),
    .addr       (addr),
    .rs2_data   (rs2_data),
    .resv_clear (resv_clear),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .misaligned (misaligned),
    .illegal    (illegal),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];
  bit          rand_wait = 1'b0;
  bit          stall_wr = 1'b0;
  int          wait_cnt = 0;
  int          req_cycles = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (mem_req) begin
      req_cycles++;
      if (mem_we && stall_wr) begin
        mem_ready = 1'b0;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        mem_ready = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem_rd(mem_addr);
        wait_cnt = rand_wait ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  // {check_result, misaligned, illegal, result}
  logic [34:0] exp_q[$];
  bit          clr_at_start = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] mk(input bit chk, input bit mis, input bit ill,
                                     input logic [31:0] res);
    return {chk, mis, ill, res};
  endfunction

  function automatic logic [31:0] amo_ref(input logic [4:0] f5, input logic [31:0] o,
                                          input logic [31:0] d);
    case (f5)
      5'b00001: return d;
      5'b00000: return o + d;
      5'b00100: return o ^ d;
      5'b01100: return o & d;
      5'b01000: return o | d;
      5'b10000: return ($signed(o) < $signed(d)) ? o : d;
      5'b10100: return ($signed(o) > $signed(d)) ? o : d;
      5'b11000: return (o < d) ? o : d;
      default:  return (o > d) ? o : d;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input string tag, input bit lr, input bit sc, input bit amo,
                       input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                       input logic [34:0] exp, input int exp_lat, input bit exp_no_mem);
    int          lat;
    int          req0;
    logic [34:0] e;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    is_lr = lr; is_sc = sc; is_amo = amo; amo_funct5 = f5; addr = a; rs2_data = d;
    resv_clear = clr_at_start;
    start = 1'b1;
    req0 = req_cycles;
    @(posedge clk); #1;
    start = 1'b0; is_lr = 1'b0; is_sc = 1'b0; is_amo = 1'b0; resv_clear = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " done seen"}, done, 1);
    e = exp_q.pop_front();
    if (e[34]) check({tag, " result"}, result, e[31:0]);
    check({tag, " misaligned"}, misaligned, e[33]);
    check({tag, " illegal"}, illegal, e[32]);
    if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
    if (exp_no_mem) check({tag, " no mem_req"}, req_cycles - req0, 0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    resv_clear = 1'b1;
    @(posedge clk); #1;
    resv_clear = 1'b0;
  endtask

  localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_MIN = 5'b10000,
                         F_MINU = 5'b11000;

  logic [4:0] legal_f5 [9] = '{5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
                               5'b10000, 5'b10100, 5'b11000, 5'b11100};

  // ---------------- main sequence ----------------
  initial begin
    int to;
    logic [31:0] a, d, old_v, new_v;
    logic [4:0]  f5;

    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst flags", {misaligned, illegal}, 0);
    rst_n = 1'b1;

    mem[32'h100] = 32'hDEADBEEF;
    do_op("lr 100", 1, 0, 0, 0, 32'h100, 0, mk(1, 0, 0, 32'hDEADBEEF), 2, 0);
    do_op("sc 100 pass", 0, 1, 0, 0, 32'h100, 5, mk(1, 0, 0, 0), 2, 0);
    check("sc mem 100", mem_rd(32'h100), 5);
    do_op("sc no lr", 0, 1, 0, 0, 32'h100, 6, mk(1, 0, 0, 1), 1, 1);

    do_op("lr 100 b", 1, 0, 0, 0, 32'h100, 0, mk(1, 0, 0, 5), 2, 0);
    pulse_clear();
    do_op("sc after clear", 0, 1, 0, 0, 32'h100, 9, mk(1, 0, 0, 1), 1, 1);
    check("mem 100 kept", mem_rd(32'h100), 5);

    do_op("lr 100 c", 1, 0, 0, 0, 32'h100, 0, mk(1, 0, 0, 5), 2, 0);
    clr_at_start = 1'b1;
    do_op("sc with clear", 0, 1, 0, 0, 32'h100, 9, mk(1, 0, 0, 1), 1, 1);
    clr_at_start = 1'b0;

    mem[32'h200] = 32'h7FFFFFFF;
    do_op("amoadd", 0, 0, 1, F_ADD, 32'h200, 1, mk(1, 0, 0, 32'h7FFFFFFF), 3, 0);
    check("amoadd mem", mem_rd(32'h200), 32'h80000000);

    mem[32'h204] = 32'hFFFFFFFF;
    mem[32'h208] = 32'hFFFFFFFF;
    do_op("amomin", 0, 0, 1, F_MIN, 32'h204, 1, mk(1, 0, 0, 32'hFFFFFFFF), 3, 0);
    check("amomin mem", mem_rd(32'h204), 32'hFFFFFFFF);
    do_op("amominu", 0, 0, 1, F_MINU, 32'h208, 1, mk(1, 0, 0, 32'hFFFFFFFF), 3, 0);
    check("amominu mem", mem_rd(32'h208), 1);

    do_op("amo misaligned", 0, 0, 1, F_ADD, 32'h202, 1, mk(0, 1, 0, 0), 1, 1);
    do_op("amo illegal", 0, 0, 1, 5'b00010, 32'h200, 1, mk(0, 0, 1, 0), 1, 1);
    check("illegal mem kept", mem_rd(32'h200), 32'h80000000);

    // LR+SC flagged together behaves as LR; the following SC then succeeds.
    do_op("lr+sc prio", 1, 1, 0, 0, 32'h200, 3, mk(1, 0, 0, 32'h80000000), 2, 0);
    do_op("sc after prio", 0, 1, 0, 0, 32'h200, 3, mk(1, 0, 0, 0), 2, 0);
    check("prio sc mem", mem_rd(32'h200), 3);

    // AMO to the reserved word kills the reservation.
    do_op("lr 100 d", 1, 0, 0, 0, 32'h100, 0, mk(1, 0, 0, 5), 2, 0);
    do_op("amoswap resv", 0, 0, 1, F_SWAP, 32'h100, 7, mk(1, 0, 0, 5), 3, 0);
    do_op("sc after amo", 0, 1, 0, 0, 32'h100, 8, mk(1, 0, 0, 1), 1, 1);
    check("swap mem", mem_rd(32'h100), 7);

    // Random AMOs with wait states.
    rand_wait = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = 32'h600 + 32'(4 * $urandom_range(0, 3));
      f5 = legal_f5[$urandom_range(0, 8)];
      d = $urandom;
      if (i % 4 == 0) mem[a] = $urandom;
      old_v = mem_rd(a);
      new_v = amo_ref(f5, old_v, d);
      do_op("rand amo", 0, 0, 1, f5, a, d, mk(1, 0, 0, old_v), 0, 0);
      check("rand amo mem", mem_rd(a), new_v);
    end
    rand_wait = 1'b0;
    @(posedge clk); #1;
    wait_cnt = 0;

    // Reset during a stalled WRITE, then an SC to the earlier LR word fails.
    mem[32'h300] = 32'h11;
    mem[32'h400] = 32'h40;
    do_op("lr 300", 1, 0, 0, 0, 32'h300, 0, mk(1, 0, 0, 32'h11), 2, 0);
    stall_wr = 1'b1;
    @(posedge clk); #1;
    is_amo = 1'b1; amo_funct5 = F_ADD; addr = 32'h400; rs2_data = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; is_amo = 1'b0;
    to = 0;
    while (!mem_we && to < 20) begin
      @(posedge clk); #1;
      to++;
    end
    check("stall in write", {mem_req, mem_we}, 2'b11);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mem_req drop", mem_req, 0);
    check("rst busy drop", busy, 0);
    check("rst result clr", result, 0);
    check("mem 400 unwritten", mem_rd(32'h400), 32'h40);
    stall_wr = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    do_op("sc after reset", 0, 1, 0, 0, 32'h300, 2, mk(1, 0, 0, 1), 1, 1);
    check("mem 300 kept", mem_rd(32'h300), 32'h11);

    check("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
